i2c_arbiter: RTL and testbench
==============================

// Module: i2c_arbiter
// PURPOSE
//   Shares the single i2c master (start/addr/data/rw in, ready out) between
//   NREQ on-chip requesters. Round-robin arbitration; latches winner's command,
//   sequences master start/ready handshake, returns per-requester done/err.
//   Sits between requester blocks and the i2c master instance.
// PARAMETERS
//   NREQ     4     number of requesters (2..8)
//   TO_MAX   1023  timeout in clk cycles per phase (ISSUE or WAIT_DONE); 10-bit counter
// PORTS
//   clk       in   1        system clock, rising edge
//   rst       in   1        synchronous reset, active-high
//   req       in   NREQ     per-requester request level
//   req_addr  in   7*NREQ   7-bit slave address, requester i at [7*i+6:7*i]
//   req_data  in   8*NREQ   write byte, requester i at [8*i+7:8*i]
//   req_rw    in   NREQ     1=read, 0=write
//   gnt       out  NREQ     one-cycle grant pulse, one-hot
//   done      out  NREQ     one-cycle completion pulse, one-hot
//   err       out  NREQ     one-cycle timeout pulse, one-hot
//   busy      out  1        high whenever state != IDLE
//   m_start   out  1        to master start
//   m_addr    out  7        to master addr (latched)
//   m_data    out  8        to master data (latched)
//   m_rw      out  1        to master rw (latched)
//   m_ready   in   1        from master ready (1 = master idle)
// BEHAVIOUR
//   Reset: state=IDLE, rr_ptr=0, to_cnt=0; gnt/done/err/m_start/busy=0;
//     m_addr=0, m_data=0, m_rw=0. rst mid-transfer aborts at once; no done/err.
//   All outputs registered. States: IDLE, ISSUE, WAIT_DONE.
//   IDLE: if |req && m_ready: winner = first set req at/after rr_ptr (wrap
//     NREQ-1 -> 0). Next cycle: state=ISSUE, gnt[winner]=1, m_start=1,
//     m_addr/m_data/m_rw latched from winner, rr_ptr=(winner+1)%NREQ, to_cnt=0.
//     req with m_ready=0 -> stay IDLE, no grant.
//   ISSUE: m_start held high. m_ready==0 -> WAIT_DONE, m_start=0, to_cnt=0.
//     to_cnt==TO_MAX -> err[winner] pulse, m_start=0, IDLE.
//   WAIT_DONE: m_ready==1 -> done[winner] pulse, IDLE. to_cnt==TO_MAX ->
//     err[winner] pulse, IDLE.
//   to_cnt increments every cycle in ISSUE/WAIT_DONE, saturates at TO_MAX.
//   Latency: req (with m_ready=1) sampled cycle N -> gnt/m_start high N+1.
//   Min turnaround: done pulse in IDLE cycle; new grant earliest next cycle.
//   Requester: hold req and its command until gnt; may drop req after gnt.
//     Command inputs not sampled after grant. req dropped before grant ignored.
//   Simultaneous reqs: exactly one grant; others wait, no starvation (each
//     requester served within NREQ grants). gnt/done/err never >1 bit set.
//   m_addr/m_data/m_rw stable from ISSUE entry until next grant.
// TESTING
//   1 req=0001 addr0=7'h50 data0=8'h55 rw0=0, master model drops ready 3 cyc
//     after start, raises 20 cyc later -> gnt=0001 at N+1, m_addr=50 m_data=55,
//     m_start high 3 cyc, done=0001 one cycle, busy low afterward.
//   2 req=1111 held, 4 back-to-back transfers -> grant order 0,1,2,3, then 0;
//     each gnt/done one-hot; m_addr tracks winner.
//   3 rr_ptr=2 (after serving 1), req=0011 -> requester 0 granted before 1.
//   4 master never drops ready -> err pulse TO_MAX+1 cyc after gnt, no done,
//     m_start low, IDLE; same for ready never returning in WAIT_DONE.
//   5 rst=1 during WAIT_DONE -> next cycle all outputs reset values, no
//     done/err; after rst=0, pending req granted from rr_ptr=0.
//   6 req=0100 while m_ready=0 for 10 cyc -> no gnt; m_ready=1 -> gnt next cycle.

Source files
------------

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin sharing of one i2c master among NREQ requesters,
// with a per-phase timeout and registered one-hot grant/done/err pulses.
module i2c_arbiter #(
   parameter int NREQ   = 4,
   parameter int TO_MAX = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [7*NREQ-1:0] req_addr,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_rw,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic [NREQ-1:0]   err,
   output logic              busy,
   output logic              m_start,
   output logic [6:0]        m_addr,
   output logic [7:0]        m_data,
   output logic              m_rw,
   input  logic              m_ready
);
   localparam int PW = $clog2(NREQ);
   localparam int TW = $clog2(TO_MAX + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
   state_t state, state_n;
   logic [PW-1:0] rr_ptr, rr_ptr_n, win, win_n, off, pick;
   logic [PW:0] sum;
   logic [NREQ-1:0] rot, gnt_n, done_n, err_n;
   logic [TW-1:0] to_cnt, to_cnt_n;
   logic m_start_n, m_rw_n, pick_rw, to_hit;
   logic [6:0] m_addr_n, pick_addr;
   logic [7:0] m_data_n, pick_data;
   // rotate so bit 0 is the requester at rr_ptr; the lowest set bit wins
   always_comb begin
      rot = NREQ'({req, req} >> rr_ptr);
      off = '0;
      for (int i = NREQ - 1; i >= 0; i--) if (rot[i]) off = PW'(i);
      sum = {1'b0, rr_ptr} + {1'b0, off};
      pick = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : PW'(sum);
      pick_addr = '0;
      pick_data = '0;
      pick_rw = 1'b0;
      for (int i = 0; i < NREQ; i++) if (pick == PW'(i)) begin
         pick_addr = req_addr[7*i +: 7];
         pick_data = req_data[8*i +: 8];
         pick_rw = req_rw[i];
      end
   end
   assign to_hit = to_cnt == TW'(TO_MAX);
   always_comb begin
      state_n = state;
      rr_ptr_n = rr_ptr;
      win_n = win;
      to_cnt_n = (state == IDLE) ? '0 : to_hit ? to_cnt : to_cnt + 1'b1;
      gnt_n = '0;
      done_n = '0;
      err_n = '0;
      m_start_n = m_start;
      m_addr_n = m_addr;
      m_data_n = m_data;
      m_rw_n = m_rw;
      case (state)
         IDLE: if (|req && m_ready) begin
            state_n = ISSUE;
            win_n = pick;
            gnt_n = NREQ'(1) << pick;
            m_start_n = 1'b1;
            m_addr_n = pick_addr;
            m_data_n = pick_data;
            m_rw_n = pick_rw;
            rr_ptr_n = (pick == PW'(NREQ - 1)) ? '0 : pick + 1'b1;
         end
         ISSUE: if (!m_ready) begin
            state_n = WAIT_DONE;
            m_start_n = 1'b0;
            to_cnt_n = '0;
         end else if (to_hit) begin
            state_n = IDLE;
            m_start_n = 1'b0;
            err_n = NREQ'(1) << win;
         end
         WAIT_DONE: if (m_ready) begin
            state_n = IDLE;
            done_n = NREQ'(1) << win;
         end else if (to_hit) begin
            state_n = IDLE;
            err_n = NREQ'(1) << win;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rr_ptr <= '0;
         win <= '0;
         to_cnt <= '0;
         gnt <= '0;
         done <= '0;
         err <= '0;
         busy <= 1'b0;
         m_start <= 1'b0;
         m_addr <= '0;
         m_data <= '0;
         m_rw <= 1'b0;
      end else begin
         state <= state_n;
         rr_ptr <= rr_ptr_n;
         win <= win_n;
         to_cnt <= to_cnt_n;
         gnt <= gnt_n;
         done <= done_n;
         err <= err_n;
         busy <= state_n != IDLE;
         m_start <= m_start_n;
         m_addr <= m_addr_n;
         m_data <= m_data_n;
         m_rw <= m_rw_n;
      end
   end
endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: randomized scoreboard bench for i2c_arbiter with a
// round-robin reference model and a behavioural i2c master.
module tb_i2c_arbiter;
   localparam int NREQ = 4;
   localparam int TO_MAX = 1023;
   localparam int MAXR = 4;
   typedef struct {int idx; logic [6:0] a; logic [7:0] d; logic rw;} gexp_t;
   typedef struct {int idx; bit is_err; int lat; int starts;} cexp_t;
   logic clk = 1'b0, rst = 1'b1, mr = 1'b1, hold = 1'b0;
   logic m_ready, busy, m_start, m_rw;
   logic [NREQ-1:0] req = '0, req_rw = '0, gnt, done, err;
   logic [7*NREQ-1:0] req_addr = '0;
   logic [8*NREQ-1:0] req_data = '0;
   logic [6:0] m_addr;
   logic [7:0] m_data;
   gexp_t gq[$];
   cexp_t cq[$];
   int vectors = 0, miscompares = 0, cyc = 0, ptr = 0;
   int mode = 0, drop_dly = 3, busy_len = 5, ready_cyc = 0;
   int cnt[NREQ], served[NREQ];
   logic [6:0] ca[NREQ][MAXR];
   logic [7:0] cd[NREQ][MAXR];
   logic crw[NREQ][MAXR];

   assign m_ready = mr & ~hold;

   i2c_arbiter #(.NREQ(NREQ), .TO_MAX(TO_MAX)) dut (
      .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
      .req_rw(req_rw), .gnt(gnt), .done(done), .err(err), .busy(busy),
      .m_start(m_start), .m_addr(m_addr), .m_data(m_data), .m_rw(m_rw),
      .m_ready(m_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_gnt"}, gnt, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_m_start"}, m_start, 0);
      chk({tag, "_m_addr"}, m_addr, 0);
      chk({tag, "_m_data"}, m_data, 0);
      chk({tag, "_m_rw"}, m_rw, 0);
   endtask

   task automatic load(input int i, input int k);
      req_addr[7*i +: 7] = ca[i][k];
      req_data[8*i +: 8] = cd[i][k];
      req_rw[i] = crw[i][k];
   endtask

   // Reference: every outstanding request is served in round-robin order from ptr.
   task automatic predict();
      int left[NREQ], k[NREQ];
      int tot, w, c;
      tot = 0;
      for (int i = 0; i < NREQ; i++) begin
         k[i] = served[i];
         left[i] = cnt[i] - served[i];
         tot += left[i];
      end
      repeat (tot) begin
         w = -1;
         for (int s = 0; s < NREQ; s++) begin
            c = (ptr + s) % NREQ;
            if (w < 0 && left[c] > 0) w = c;
         end
         gq.push_back('{w, ca[w][k[w]], cd[w][k[w]], crw[w][k[w]]});
         cq.push_back('{w, mode != 0, (mode == 1) ? TO_MAX + 1 : drop_dly + TO_MAX + 1,
                        (mode == 1) ? TO_MAX + 1 : drop_dly});
         left[w]--;
         k[w]++;
         ptr = (w + 1) % NREQ;
      end
   endtask

   task automatic issue(input logic [NREQ-1:0] mask, input int reps, input bit dir);
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
         cnt[i] = mask[i] ? reps : 0;
         served[i] = 0;
         for (int k = 0; k < MAXR; k++) begin
            ca[i][k] = 7'($urandom);
            cd[i][k] = 8'($urandom);
            crw[i][k] = 1'($urandom);
         end
      end
      if (dir) begin
         ca[0][0] = 7'h50;
         cd[0][0] = 8'h55;
         crw[0][0] = 1'b0;
      end
      predict();
      for (int i = 0; i < NREQ; i++) if (mask[i]) begin
         load(i, 0);
         req[i] = 1'b1;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (cq.size() > 0 && t < 20000) begin
         @(negedge clk);
         t++;
      end
      if (cq.size() > 0) begin
         chk("drain_timeout", cq.size(), 0);
         gq.delete();
         cq.delete();
      end
   endtask

   task automatic run_batch(input logic [NREQ-1:0] mask, input int reps, input bit dir);
      issue(mask, reps, dir);
      drain();
   endtask

   // requesters: keep req up until the planned number of grants is reached
   initial forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) if (gnt[i] && req[i]) begin
         served[i]++;
         if (served[i] < cnt[i]) load(i, served[i]);
         else req[i] = 1'b0;
      end
   end

   // master: mode 0 normal, 1 never leaves ready, 2 never returns ready
   initial forever begin
      @(negedge clk);
      if (m_start) begin
         if (mode == 1) begin
            for (int t = 0; t < 4 * TO_MAX && m_start; t++) @(negedge clk);
         end else begin
            repeat (drop_dly - 1) @(negedge clk);
            mr = 1'b0;
            if (mode == 0) repeat (busy_len) @(negedge clk);
            else for (int t = 0; t < 4 * TO_MAX && err == '0; t++) @(negedge clk);
            mr = 1'b1;
            ready_cyc = cyc;
         end
      end
   end

   // monitor: pop and compare whenever the DUT presents a grant or completion
   initial begin
      int gcyc, scnt;
      logic [6:0] la;
      gexp_t g;
      cexp_t c;
      gcyc = 0;
      scnt = 0;
      la = '0;
      forever begin
         @(negedge clk);
         if (gnt != '0) scnt = 0;
         if (m_start) scnt++;
         if (gnt != '0) begin
            gcyc = cyc;
            if (gq.size() == 0) chk("gnt_unexpected", gnt, 0);
            else begin
               g = gq.pop_front();
               la = g.a;
               chk("gnt", gnt, 1 << g.idx);
               chk("m_addr", m_addr, g.a);
               chk("m_data", m_data, g.d);
               chk("m_rw", m_rw, g.rw);
               chk("busy_at_gnt", busy, 1);
               chk("m_start_at_gnt", m_start, 1);
            end
         end
         if ((done | err) != '0) begin
            if (cq.size() == 0) chk("cpl_unexpected", {done, err}, 0);
            else begin
               c = cq.pop_front();
               chk("done", done, c.is_err ? 0 : 1 << c.idx);
               chk("err", err, c.is_err ? 1 << c.idx : 0);
               chk("cpl_latency", c.is_err ? cyc - gcyc : cyc - ready_cyc, c.is_err ? c.lat : 1);
               chk("m_start_cycles", scnt, c.starts);
               chk("busy_after", busy, 0);
               chk("m_start_after", m_start, 0);
               chk("m_addr_stable", m_addr, la);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;
      mode = 0;
      drop_dly = 3;
      busy_len = 20;
      run_batch(4'b0001, 1, 1'b1);
      drop_dly = 2;
      busy_len = 3;
      run_batch(4'b1111, 2, 1'b0);
      run_batch(4'b0010, 1, 1'b0);
      run_batch(4'b0011, 1, 1'b0);
      hold = 1'b1;
      issue(4'b0100, 1, 1'b0);
      repeat (10) begin
         @(negedge clk);
         chk("gnt_while_not_ready", gnt, 0);
      end
      hold = 1'b0;
      @(negedge clk);
      chk("gnt_after_ready", gnt, 4'b0100);
      drain();
      mode = 1;
      run_batch(4'b1000, 1, 1'b0);
      mode = 2;
      drop_dly = 2;
      run_batch(4'b0001, 1, 1'b0);
      mode = 0;
      repeat (30) begin
         drop_dly = $urandom_range(1, 4);
         busy_len = $urandom_range(1, 6);
         run_batch(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom_range(1, MAXR), 1'b0);
      end
      drop_dly = 2;
      busy_len = 10;
      issue(4'b0010, 1, 1'b0);
      for (int t = 0; t < 100 && !(busy && !m_start); t++) @(negedge clk);
      chk("reach_wait_done", busy && !m_start, 1);
      hold = 1'b1;
      cnt[0] = 1;
      cnt[3] = 1;
      load(0, 0);
      load(3, 0);
      req[0] = 1'b1;
      req[3] = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset("abort");
      gq.delete();
      cq.delete();
      ptr = 0;
      rst = 1'b0;
      hold = 1'b0;
      predict();
      drain();
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
